// File: rtl/rf_wr_sched.sv
// ---------------------------------------------------------------------------
// rf_wr_sched
//
// Write-port scheduler for the 32x32 two-read/one-write register file.
// Three writeback requesters (0 = ALU, 1 = memory load, 2 = debug/coprocessor)
// share the single register file write port. A round-robin arbiter picks at
// most one request per cycle, the winner is registered onto the write port,
// and the registered write is forwarded onto both read paths so consumers
// never see stale data while the write is in flight.
//
// Handshake: requester n raises wr_req_n and holds wr_addr_n/wr_data_n stable
// until it samples wr_ack_n=1 at a rising edge of rf_clock; in the following
// cycle it may drop wr_req_n or present a new request. wr_ack_n is
// combinational and is never asserted while sched_hold or rf_reset is high.
//
// Optional feature (macro RF_WR_SCHED_R0_ZERO_EN):
//   defined   - register 0 is hardwired zero: writes to address 0 are acked
//               but never reach the write port, and reads of address 0
//               return 0.
//   undefined - address 0 is an ordinary register.
//
// Ports:
//   rf_clock           in   clock, all state on rising edge
//   rf_reset           in   synchronous active-high reset
//   sched_hold         in   suppress all grants (requests stay pending)
//   wr_req_0/1/2       in   requester n has a write pending
//   wr_addr_0/1/2      in   destination register of requester n
//   wr_data_0/1/2      in   write data of requester n
//   wr_ack_0/1/2       out  request n granted this cycle (combinational)
//   rf_wr_enable       out  registered write enable to the register file
//   rf_wr_addr         out  registered write address
//   rf_wr_data         out  registered write data
//   rd_addr_0/1        in   read addresses (shared with the register file)
//   rf_rd_data_0/1     in   raw read data from the register file
//   rd_data_0/1        out  forwarded read data to consumers
//   sched_idle         out  registered: no grant and no request last cycle
// ---------------------------------------------------------------------------
module rf_wr_sched #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              rf_clock,
    input  logic              rf_reset,
    input  logic              sched_hold,
    input  logic              wr_req_0,
    input  logic              wr_req_1,
    input  logic              wr_req_2,
    input  logic [ADDR_W-1:0] wr_addr_0,
    input  logic [ADDR_W-1:0] wr_addr_1,
    input  logic [ADDR_W-1:0] wr_addr_2,
    input  logic [DATA_W-1:0] wr_data_0,
    input  logic [DATA_W-1:0] wr_data_1,
    input  logic [DATA_W-1:0] wr_data_2,
    output logic              wr_ack_0,
    output logic              wr_ack_1,
    output logic              wr_ack_2,
    output logic              rf_wr_enable,
    output logic [ADDR_W-1:0] rf_wr_addr,
    output logic [DATA_W-1:0] rf_wr_data,
    input  logic [ADDR_W-1:0] rd_addr_0,
    input  logic [ADDR_W-1:0] rd_addr_1,
    input  logic [DATA_W-1:0] rf_rd_data_0,
    input  logic [DATA_W-1:0] rf_rd_data_1,
    output logic [DATA_W-1:0] rd_data_0,
    output logic [DATA_W-1:0] rd_data_1,
    output logic              sched_idle
);

    // Requester indices; the round-robin pointer holds the last granted one.
    localparam logic [1:0] REQ_ALU = 2'd0;
    localparam logic [1:0] REQ_MEM = 2'd1;
    localparam logic [1:0] REQ_DBG = 2'd2;

    logic [1:0]        last_grant_q, last_grant_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              idle_q, idle_d;

    logic              grant_vld;
    logic [1:0]        grant_idx;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              any_req;

    assign any_req = wr_req_0 | wr_req_1 | wr_req_2;

    // Round-robin search starting one past the last grant.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = REQ_ALU;
        if (!rf_reset && !sched_hold) begin
            case (last_grant_q)
                REQ_ALU: begin
                    if (wr_req_1) begin
                        grant_vld = 1'b1; grant_idx = REQ_MEM;
                    end else if (wr_req_2) begin
                        grant_vld = 1'b1; grant_idx = REQ_DBG;
                    end else if (wr_req_0) begin
                        grant_vld = 1'b1; grant_idx = REQ_ALU;
                    end
                end
                REQ_MEM: begin
                    if (wr_req_2) begin
                        grant_vld = 1'b1; grant_idx = REQ_DBG;
                    end else if (wr_req_0) begin
                        grant_vld = 1'b1; grant_idx = REQ_ALU;
                    end else if (wr_req_1) begin
                        grant_vld = 1'b1; grant_idx = REQ_MEM;
                    end
                end
                default: begin
                    if (wr_req_0) begin
                        grant_vld = 1'b1; grant_idx = REQ_ALU;
                    end else if (wr_req_1) begin
                        grant_vld = 1'b1; grant_idx = REQ_MEM;
                    end else if (wr_req_2) begin
                        grant_vld = 1'b1; grant_idx = REQ_DBG;
                    end
                end
            endcase
        end
    end

    assign wr_ack_0 = grant_vld && (grant_idx == REQ_ALU);
    assign wr_ack_1 = grant_vld && (grant_idx == REQ_MEM);
    assign wr_ack_2 = grant_vld && (grant_idx == REQ_DBG);

    // Winner's address/data mux.
    always_comb begin
        sel_addr = wr_addr_0;
        sel_data = wr_data_0;
        case (grant_idx)
            REQ_MEM: begin
                sel_addr = wr_addr_1;
                sel_data = wr_data_1;
            end
            REQ_DBG: begin
                sel_addr = wr_addr_2;
                sel_data = wr_data_2;
            end
            default: begin
                sel_addr = wr_addr_0;
                sel_data = wr_data_0;
            end
        endcase
    end

    // Next-state for the write stage and scheduler bookkeeping.
    always_comb begin
        last_grant_d = last_grant_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        if (grant_vld) begin
            last_grant_d = grant_idx;
            wr_addr_d    = sel_addr;
            wr_data_d    = sel_data;
        end
`ifdef RF_WR_SCHED_R0_ZERO_EN
        // Writes to r0 are acked but suppressed at the write port.
        wr_en_d = grant_vld && (sel_addr != '0);
`else
        wr_en_d = grant_vld;
`endif
        idle_d = !grant_vld && !any_req;
    end

    always_ff @(posedge rf_clock) begin
        if (rf_reset) begin
            last_grant_q <= REQ_DBG;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            idle_q       <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            idle_q       <= idle_d;
        end
    end

    assign rf_wr_enable = wr_en_q;
    assign rf_wr_addr   = wr_addr_q;
    assign rf_wr_data   = wr_data_q;
    assign sched_idle   = idle_q;

    // Forwarding: only the registered (already granted) write is bypassed;
    // pending requests are invisible to readers.
    always_comb begin
        rd_data_0 = rf_rd_data_0;
        rd_data_1 = rf_rd_data_1;
        if (wr_en_q && (rd_addr_0 == wr_addr_q)) begin
            rd_data_0 = wr_data_q;
        end
        if (wr_en_q && (rd_addr_1 == wr_addr_q)) begin
            rd_data_1 = wr_data_q;
        end
`ifdef RF_WR_SCHED_R0_ZERO_EN
        if (rd_addr_0 == '0) begin
            rd_data_0 = '0;
        end
        if (rd_addr_1 == '0) begin
            rd_data_1 = '0;
        end
`endif
    end

endmodule

// File: tb/tb_rf_wr_sched.sv
// ---------------------------------------------------------------------------
// tb_rf_wr_sched
//
// Directed bench for rf_wr_sched. The driver sets inputs on the falling edge,
// checks the combinational acks against hand-computed values and pushes the
// expected register-file write for each expected grant into exp_q. A monitor
// pops exp_q whenever rf_wr_enable is seen after a rising edge. A small
// register file model closes the read path so forwarding and final contents
// can be observed through rd_data_0/1.
// ---------------------------------------------------------------------------
module tb_rf_wr_sched;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst;
    logic              hold;
    logic [2:0]        req;
    logic [ADDR_W-1:0] addr [3];
    logic [DATA_W-1:0] data [3];
    logic              ack_0, ack_1, ack_2;
    logic [2:0]        ack;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_addr_0, rd_addr_1;
    logic [DATA_W-1:0] rf_rd_0, rf_rd_1;
    logic [DATA_W-1:0] rd_0, rd_1;
    logic              idle;

    logic [DATA_W-1:0] mem [32];
    logic [2:0]        unacked;

    logic [ADDR_W+DATA_W-1:0] exp_q [$];
    logic [ADDR_W+DATA_W-1:0] exp_e;

    int checks;
    int failures;

    assign ack = {ack_2, ack_1, ack_0};

    rf_wr_sched #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .rf_clock     (clk),
        .rf_reset     (rst),
        .sched_hold   (hold),
        .wr_req_0     (req[0]),
        .wr_req_1     (req[1]),
        .wr_req_2     (req[2]),
        .wr_addr_0    (addr[0]),
        .wr_addr_1    (addr[1]),
        .wr_addr_2    (addr[2]),
        .wr_data_0    (data[0]),
        .wr_data_1    (data[1]),
        .wr_data_2    (data[2]),
        .wr_ack_0     (ack_0),
        .wr_ack_1     (ack_1),
        .wr_ack_2     (ack_2),
        .rf_wr_enable (wr_en),
        .rf_wr_addr   (wr_addr),
        .rf_wr_data   (wr_data),
        .rd_addr_0    (rd_addr_0),
        .rd_addr_1    (rd_addr_1),
        .rf_rd_data_0 (rf_rd_0),
        .rf_rd_data_1 (rf_rd_1),
        .rd_data_0    (rd_0),
        .rd_data_1    (rd_1),
        .sched_idle   (idle)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- register file model ----------------
    // Known background pattern; r7 starts at zero for the forwarding case.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                mem[i] <= (i == 7) ? 32'h0 : (32'hA5A5_0000 | i);
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rf_rd_0 = mem[rd_addr_0];
    assign rf_rd_1 = mem[rd_addr_1];

    // ---------------- compare helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge with inputs already applied: checks the acks,
    // records the expected write, then advances to the next falling edge.
    task automatic cyc(input logic [2:0] exp_ack, input string name);
        #1;
        chk(name, {29'd0, ack}, {29'd0, exp_ack});
        for (int n = 0; n < 3; n++) begin
            if (exp_ack[n]) begin
`ifdef RF_WR_SCHED_R0_ZERO_EN
                if (addr[n] != '0) exp_q.push_back({addr[n], data[n]});
`else
                exp_q.push_back({addr[n], data[n]});
`endif
            end
        end
        @(negedge clk);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(posedge clk) begin
        #1;
        if (wr_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr=%0d data=0x%08h expected no write",
                         wr_addr, wr_data);
            end else begin
                exp_e = exp_q.pop_front();
                chk("wr_addr", {27'd0, wr_addr}, {27'd0, exp_e[ADDR_W+DATA_W-1:DATA_W]});
                chk("wr_data", wr_data, exp_e[DATA_W-1:0]);
            end
        end
    end

    // Requester handshake: a request may not be withdrawn before its ack.
    always @(posedge clk) begin
        for (int n = 0; n < 3; n++) begin
            if (unacked[n] === 1'b1 && !req[n]) begin
                failures++;
                $display("FAIL handshake_drop: requester %0d dropped request before ack", n);
            end
        end
        if (rst) unacked <= 3'b000;
        else     unacked <= req & ~ack;
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        failures++;
        $display("FAIL timeout: got no end of test expected end before 200000");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        hold      = 1'b0;
        req       = 3'b000;
        rd_addr_0 = '0;
        rd_addr_1 = '0;
        for (int n = 0; n < 3; n++) begin
            addr[n] = '0;
            data[n] = '0;
        end
        @(negedge clk);
        @(negedge clk);

        // Reset state, and acks forced low while in reset.
        chk("rst_wr_enable", {31'd0, wr_en}, 32'd0);
        chk("rst_wr_addr", {27'd0, wr_addr}, 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_idle", {31'd0, idle}, 32'd1);
        req = 3'b111;
        cyc(3'b000, "ack_in_reset");
        req = 3'b000;
        rst = 1'b0;

        // 1: single request from requester 1.
        addr[1] = 5'd5; data[1] = 32'hDEAD_BEEF; req[1] = 1'b1;
        cyc(3'b010, "t1_ack");
        req[1] = 1'b0;
        chk("t1_wr_enable_hi", {31'd0, wr_en}, 32'd1);
        chk("t1_idle_lo", {31'd0, idle}, 32'd0);
        cyc(3'b000, "t1_no_ack");
        chk("t1_wr_enable_lo", {31'd0, wr_en}, 32'd0);
        chk("t1_addr_hold", {27'd0, wr_addr}, 32'd5);
        chk("t1_idle_hi", {31'd0, idle}, 32'd1);

        // 2: all three requesting from reset, rotation 0,1,2,0,1,2.
        rst = 1'b1;
        cyc(3'b000, "t2_reset");
        rst = 1'b0;
        addr[0] = 5'd10; data[0] = 32'hA0;
        addr[1] = 5'd11; data[1] = 32'hB1;
        addr[2] = 5'd12; data[2] = 32'hC2;
        req = 3'b111;
        for (int i = 0; i < 6; i++) begin
            cyc(3'b001 << (i % 3), "t2_rotate_ack");
            data[i % 3] = data[i % 3] + 32'd1;
            if (i >= 3) req[i % 3] = 1'b0;
            chk("t2_wr_enable_run", {31'd0, wr_en}, 32'd1);
        end
        cyc(3'b000, "t2_drained");
        chk("t2_wr_enable_end", {31'd0, wr_en}, 32'd0);

        // 3: hold blocks grants; release grants requester 0 immediately.
        hold = 1'b1;
        addr[0] = 5'd1; data[0] = 32'h11; req[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(3'b000, "t3_hold_ack");
            chk("t3_hold_wr_enable", {31'd0, wr_en}, 32'd0);
        end
        chk("t3_hold_idle", {31'd0, idle}, 32'd0);
        hold = 1'b0;
        cyc(3'b001, "t3_release_ack");
        req[0] = 1'b0;

        // 4: forwarding of the registered write onto both read ports.
        addr[2] = 5'd7; data[2] = 32'h1234_5678; req[2] = 1'b1;
        rd_addr_0 = 5'd7; rd_addr_1 = 5'd8;
        #1;
        chk("t4_pending_not_fwd", rd_0, 32'h0);
        cyc(3'b100, "t4_ack");
        req[2] = 1'b0;
        #1;
        chk("t4_fwd_rd0", rd_0, 32'h1234_5678);
        chk("t4_nofwd_rd1", rd_1, 32'hA5A5_0008);
        rd_addr_1 = 5'd7;
        #1;
        chk("t4_fwd_rd1", rd_1, 32'h1234_5678);
        cyc(3'b000, "t4_idle");
        chk("t4_committed_rd0", rd_0, 32'h1234_5678);

        // 5: same address from requesters 0 and 2, grant order wins.
        addr[0] = 5'd3; data[0] = 32'h1;
        addr[2] = 5'd3; data[2] = 32'h2;
        req = 3'b101;
        rd_addr_0 = 5'd3; rd_addr_1 = 5'd9;
        cyc(3'b001, "t5_first_ack");
        req[0] = 1'b0;
        #1;
        chk("t5_fwd_first", rd_0, 32'h1);
        cyc(3'b100, "t5_second_ack");
        req[2] = 1'b0;
        #1;
        chk("t5_fwd_second", rd_0, 32'h2);
        cyc(3'b000, "t5_idle");
        chk("t5_final_r3", rd_0, 32'h2);

        // 6: reset while a write is registered.
        addr[1] = 5'd9; data[1] = 32'h99; req[1] = 1'b1;
        cyc(3'b010, "t6_ack");
        req[1] = 1'b0;
        rst = 1'b1;
        addr[0] = 5'd4; data[0] = 32'h40;
        addr[2] = 5'd6; data[2] = 32'h60;
        req = 3'b101;
        cyc(3'b000, "t6_ack_forced_low");
        chk("t6_wr_enable_dropped", {31'd0, wr_en}, 32'd0);
        chk("t6_idle_after_rst", {31'd0, idle}, 32'd1);
        rst = 1'b0;
        cyc(3'b001, "t6_first_after_rst");
        req[0] = 1'b0;
        cyc(3'b100, "t6_second_after_rst");
        req[2] = 1'b0;
        cyc(3'b000, "t6_idle");

        // Address 0 write and read.
        addr[0] = 5'd0; data[0] = 32'h55; req[0] = 1'b1;
        rd_addr_0 = 5'd0;
        cyc(3'b001, "r0_ack");
        req[0] = 1'b0;
        #1;
`ifdef RF_WR_SCHED_R0_ZERO_EN
        chk("r0_wr_enable_lo", {31'd0, wr_en}, 32'd0);
        chk("r0_rd_zero", rd_0, 32'h0);
`else
        chk("r0_wr_enable_hi", {31'd0, wr_en}, 32'd1);
        chk("r0_rd_fwd", rd_0, 32'h55);
`endif
        cyc(3'b000, "end_idle_a");
        cyc(3'b000, "end_idle_b");
        chk("queue_drained", exp_q.size(), 32'd0);
        chk("end_idle", {31'd0, idle}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
